// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel divider plus horizontal/vertical counters.
// Sync, active-area and strobe outputs are registered from next-state counters.
module vga_timing_gen #(
    parameter int PIX_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       hsync,
    output logic       vsync,
    output logic       active_area,
    output logic [9:0] coord_x,
    output logic [9:0] coord_y,
    output logic       pix_tick,
    output logic       line_start,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_ACT_E  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_E  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic             run_q, run_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
    logic             tick_q, tick_d, line_q, line_d, frame_q, frame_d;

    always_comb begin
        run_d   = 1'b1;
        // The first edge after reset enters pixel (0,0) as a full pixel period.
        tick_d  = !run_q || (div_q == DIV_LAST);
        div_d   = tick_d ? '0 : div_q + DIV_W'(1);
        x_d     = x_q;
        y_d     = y_q;
        if (run_q && tick_d) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        active_d = ({1'b0, x_d} < H_ACT_E) && ({1'b0, y_d} < V_ACT_E);
        hsync_d  = (({1'b0, x_d} >= HS_BEG) && ({1'b0, x_d} < HS_END)) ? HS_POL : ~HS_POL;
        vsync_d  = (({1'b0, y_d} >= VS_BEG) && ({1'b0, y_d} < VS_END)) ? VS_POL : ~VS_POL;
        line_d   = tick_d && (x_d == 10'd0);
        frame_d  = line_d && (y_d == 10'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q    <= 1'b0;
            div_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
            active_q <= 1'b0;
            tick_q   <= 1'b0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            run_q    <= run_d;
            div_q    <= div_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            tick_q   <= tick_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active_area = active_q;
    assign coord_x     = x_q;
    assign coord_y     = y_q;
    assign pix_tick    = tick_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing, a tiny 14x7 raster at PIX_DIV=1,
// and the same tiny raster at PIX_DIV=4 with active-high syncs.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic       d_hs, d_vs, d_act, d_tick, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_act, s_tick, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic       m_hs, m_vs, m_act, m_tick, m_ls, m_fs;
    logic [9:0] m_x, m_y;

    vga_timing_gen u_def (
        .clk(clk), .reset_n(reset_n), .hsync(d_hs), .vsync(d_vs), .active_area(d_act),
        .coord_x(d_x), .coord_y(d_y), .pix_tick(d_tick), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .PIX_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_small (
        .clk(clk), .reset_n(reset_n), .hsync(s_hs), .vsync(s_vs), .active_area(s_act),
        .coord_x(s_x), .coord_y(s_y), .pix_tick(s_tick), .line_start(s_ls), .frame_start(s_fs)
    );

    vga_timing_gen #(
        .PIX_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_mid (
        .clk(clk), .reset_n(reset_n), .hsync(m_hs), .vsync(m_vs), .active_area(m_act),
        .coord_x(m_x), .coord_y(m_y), .pix_tick(m_tick), .line_start(m_ls), .frame_start(m_fs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Independent raster model: n = clk edges since the first edge after reset release.
    task automatic chk_raster(input string t, input int n, input int pd,
                              input int ha, input int hf, input int hs, input int hb,
                              input int va, input int vf, input int vs, input int vb,
                              input bit hp, input bit vp,
                              input logic hsync, input logic vsync, input logic act,
                              input logic [9:0] x, input logic [9:0] y,
                              input logic tick, input logic ls, input logic fs);
        int ht, vt, p, ex, ey;
        bit etick, hwin, vwin;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        p  = n / pd;
        ex = p % ht;
        ey = (p / ht) % vt;
        etick = (n % pd) == 0;
        hwin  = (ex >= ha + hf) && (ex < ha + hf + hs);
        vwin  = (ey >= va + vf) && (ey < va + vf + vs);
        chk({t, ".coord_x"}, x, ex);
        chk({t, ".coord_y"}, y, ey);
        chk({t, ".pix_tick"}, tick, etick);
        chk({t, ".line_start"}, ls, etick && ex == 0);
        chk({t, ".frame_start"}, fs, etick && ex == 0 && ey == 0);
        chk({t, ".active"}, act, (ex < ha) && (ey < va));
        chk({t, ".hsync"}, hsync, hwin ? hp : !hp);
        chk({t, ".vsync"}, vsync, vwin ? vp : !vp);
    endtask

    initial begin
        int hs_low_clks, d_lines, d_falls, s_last, m_last;
        logic d_act_prev;

        // Reset state while held
        repeat (3) @(posedge clk);
        #1;
        chk("rst.coord_x", d_x, 0);
        chk("rst.active", d_act, 0);
        chk("rst.pix_tick", d_tick, 0);
        chk("rst.hsync", d_hs, 1);
        chk("rst.vsync", d_vs, 1);

        // Run into the middle of a line, then assert reset between edges
        @(negedge clk) reset_n = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        chk("mid.coord_x_before", d_x, 124);
        #2 reset_n = 1'b0;
        #1;
        chk("async.coord_x", d_x, 0);
        chk("async.coord_y", d_y, 0);
        chk("async.active", d_act, 0);
        chk("async.pix_tick", d_tick, 0);
        chk("async.line_start", d_ls, 0);
        chk("async.frame_start", d_fs, 0);
        chk("async.hsync", d_hs, 1);
        chk("async.vsync", d_vs, 1);
        chk("async.small_x", s_x, 0);
        chk("async.mid_hsync", m_hs, 0);
        chk("async.mid_vsync", m_vs, 0);

        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        hs_low_clks = 0;
        d_lines = 0;
        d_falls = 0;
        s_last = -1;
        m_last = -1;
        d_act_prev = 1'b0;
        for (int n = 0; n <= 3300; n++) begin
            @(posedge clk);
            #1;
            if (n == 0) begin
                chk("first.coord_x", d_x, 0);
                chk("first.coord_y", d_y, 0);
                chk("first.active", d_act, 1);
            end
            chk_raster("def", n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
                       d_hs, d_vs, d_act, d_x, d_y, d_tick, d_ls, d_fs);
            chk_raster("small", n, 1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0,
                       s_hs, s_vs, s_act, s_x, s_y, s_tick, s_ls, s_fs);
            chk_raster("mid", n, 4, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1,
                       m_hs, m_vs, m_act, m_x, m_y, m_tick, m_ls, m_fs);
            if (n < 3200 && d_hs == 1'b0) hs_low_clks++;
            if (d_ls) d_lines++;
            if (d_act_prev && !d_act) begin
                d_falls++;
                chk("def.fall_x", d_x, 640);
            end
            d_act_prev = d_act;
            if (s_fs) begin
                if (s_last >= 0) chk("small.frame_spacing", n - s_last, 98);
                s_last = n;
            end
            if (m_fs) begin
                if (m_last >= 0) chk("mid.frame_spacing", n - m_last, 392);
                m_last = n;
            end
        end
        chk("def.hsync_low_clks", hs_low_clks, 384);
        chk("def.line_pulses", d_lines, 2);
        chk("def.active_falls", d_falls, 1);
        chk("small.last_frame", s_last, 3234);
        chk("mid.last_frame", m_last, 3136);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
